// File: rtl/saph_fpu_pkg.sv
// Shared FPU operation types used by the FPU arbiter and its requesters.
package saph_fpu_pkg;

  localparam int unsigned FPU_FLOAT_W = 32;

  typedef enum logic [1:0] {
    FPU_ADD = 2'b00,
    FPU_SUB = 2'b01,
    FPU_MUL = 2'b10,
    FPU_DIV = 2'b11
  } fpu_mode_t;

  typedef struct packed {
    fpu_mode_t                mode;
    logic [FPU_FLOAT_W-1:0]   lhs;
    logic [FPU_FLOAT_W-1:0]   rhs;
  } fpu_req_t;

endpackage

// File: rtl/saph_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Reusable for any shared single-issue unit.
module saph_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] sum;

  // ptr < N and offset < N, so one conditional subtract performs the wrap
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(N)) sum = sum - SUM_W'(N);
      if (!any && req[sum[IDX_W-1:0]]) begin
        any                     = 1'b1;
        grant_idx               = sum[IDX_W-1:0];
        grant[sum[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/saph_fpu_arbiter.sv
// Shares one fixed-latency FPU between N_REQ requesters with round-robin issue;
// a requester-ID pipeline matched to the FPU latency steers results back.
module saph_fpu_arbiter
  import saph_fpu_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned FLOAT_W = FPU_FLOAT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*2-1:0]       req_mode,
  input  logic [N_REQ*FLOAT_W-1:0] req_lhs,
  input  logic [N_REQ*FLOAT_W-1:0] req_rhs,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [FLOAT_W-1:0]       rsp_res,
  input  logic                     hold,
  output logic                     busy,
  output logic                     err,
  output logic                     fpu_d_trig,
  input  logic                     fpu_d_ready,
  output logic [1:0]               fpu_d_mode,
  output logic [FLOAT_W-1:0]       fpu_d_lhs,
  output logic [FLOAT_W-1:0]       fpu_d_rhs,
  input  logic                     fpu_q_trig,
  input  logic [FLOAT_W-1:0]       fpu_q_res
);

  localparam int unsigned ID_W   = $clog2(N_REQ);
  localparam int unsigned PIPE_W = LATENCY * ID_W;

  fpu_mode_t          mode_a [N_REQ];
  logic [FLOAT_W-1:0] lhs_a  [N_REQ];
  logic [FLOAT_W-1:0] rhs_a  [N_REQ];

  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [PIPE_W-1:0]  id_q, id_d;
  logic               err_q, err_d;

  logic               last_vld;
  logic [ID_W-1:0]    last_id;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign mode_a[g] = fpu_mode_t'(req_mode[2*g +: 2]);
    assign lhs_a[g]  = req_lhs[FLOAT_W*g +: FLOAT_W];
    assign rhs_a[g]  = req_rhs[FLOAT_W*g +: FLOAT_W];
  end

  // No grant while in reset, held off by the sequencer, or FPU stalled
  always_comb begin
    eligible = '0;
    if (rst && !hold && fpu_d_ready) eligible = req_valid;
  end

  saph_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    req_ready  = grant;
    fpu_d_trig = grant_any;
    fpu_d_mode = '0;
    fpu_d_lhs  = '0;
    fpu_d_rhs  = '0;
    if (grant_any) begin
      fpu_d_mode = mode_a[grant_idx];
      fpu_d_lhs  = lhs_a[grant_idx];
      fpu_d_rhs  = rhs_a[grant_idx];
    end
  end

  // Stage 0 takes the current issue; older stages shift toward the result slot
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    vld_d = LATENCY'({vld_q, grant_any});
    id_d  = PIPE_W'({id_q, grant_idx});
    err_d = err_q | (fpu_q_trig != last_vld);
  end

  assign last_vld = vld_q[LATENCY-1];
  assign last_id  = id_q[PIPE_W-1 -: ID_W];

  always_comb begin
    rsp_valid = '0;
    rsp_res   = '0;
    if (rst && fpu_q_trig && last_vld) begin
      rsp_valid[last_id] = 1'b1;
      rsp_res            = fpu_q_res;
    end
  end

  assign busy = rst && (|vld_q);
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Bench for saph_fpu_arbiter: table of per-cycle grants plus hand sequences,
// with a latency-2 FPU model and a response scoreboard.
module tb_saph_fpu_arbiter;
  import saph_fpu_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, hold, fpu_d_ready, inject;
  logic [N-1:0]     req_valid, req_ready, rsp_valid;
  logic [2*N-1:0]   req_mode;
  logic [N*W-1:0]   req_lhs, req_rhs;
  logic [W-1:0]     rsp_res, fpu_d_lhs, fpu_d_rhs, fpu_q_res;
  logic             busy, err, fpu_d_trig, fpu_q_trig;
  logic [1:0]       fpu_d_mode;

  fpu_req_t fld [N];

  for (genvar g = 0; g < N; g++) begin : g_fld
    assign req_mode[2*g +: 2] = fld[g].mode;
    assign req_lhs[W*g +: W]  = fld[g].lhs;
    assign req_rhs[W*g +: W]  = fld[g].rhs;
  end

  saph_fpu_arbiter #(.N_REQ(N), .LATENCY(LAT), .FLOAT_W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res),
    .hold(hold), .busy(busy), .err(err),
    .fpu_d_trig(fpu_d_trig), .fpu_d_ready(fpu_d_ready),
    .fpu_d_mode(fpu_d_mode), .fpu_d_lhs(fpu_d_lhs), .fpu_d_rhs(fpu_d_rhs),
    .fpu_q_trig(fpu_q_trig), .fpu_q_res(fpu_q_res)
  );

  // Single-precision <-> real for normal numbers (enough for the test operands)
  function automatic real s2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) d = {b[31], 63'd0};
    else d = {b[31], 11'(32'(b[30:23]) + 32'd896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(32'(d[62:52]) - 32'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [1:0] mode, input logic [31:0] a,
                                           input logic [31:0] b);
    real x, y, r;
    x = s2r(a);
    y = s2r(b);
    case (mode)
      2'b00:   r = x + y;
      2'b01:   r = x - y;
      2'b10:   r = x * y;
      default: r = (y == 0.0) ? 0.0 : x / y;
    endcase
    return r2s(r);
  endfunction

  // FPU model: fixed two-cycle latency, plus an injectable spurious strobe
  logic [1:0]   m_vld  = 2'b00;
  logic [W-1:0] m_res0 = '0;
  logic [W-1:0] m_res1 = '0;
  always @(posedge clk) begin
    m_vld  <= {m_vld[0], fpu_d_trig};
    m_res0 <= fpu_d_trig ? fpu_calc(fpu_d_mode, fpu_d_lhs, fpu_d_rhs) : '0;
    m_res1 <= m_res0;
  end
  assign fpu_q_trig = m_vld[1] | inject;
  assign fpu_q_res  = m_res1;

  typedef struct {
    int           id;
    int           due;
    logic [W-1:0] res;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic         r;
    logic         h;
    logic         d;
    logic [N-1:0] v;
    logic [N-1:0] e;
  } vec_t;
  vec_t tbl[$];

  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic exp_err = 1'b0;

  task automatic add(input logic r, input logic h, input logic d, input logic [N-1:0] v,
                     input logic [N-1:0] e, input int rep);
    for (int k = 0; k < rep; k++) tbl.push_back('{r, h, d, v, e});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Check every output in the current cycle, then advance one clock
  task automatic cycle(input logic [N-1:0] exp_rdy);
    logic         slot;
    int           gi;
    logic [N-1:0] exp_rsp;
    logic [W-1:0] exp_res, e_lhs, e_rhs;
    logic [1:0]   e_mode;
    @(negedge clk);
    slot    = (sbq.size() > 0) && (sbq[0].due == cyc);
    exp_rsp = '0;
    exp_res = '0;
    if (rst && slot && fpu_q_trig) begin
      exp_rsp[sbq[0].id] = 1'b1;
      exp_res            = sbq[0].res;
    end
    gi     = oh_idx(exp_rdy);
    e_mode = '0;
    e_lhs  = '0;
    e_rhs  = '0;
    if (gi >= 0) begin
      e_mode = fld[gi].mode;
      e_lhs  = fld[gi].lhs;
      e_rhs  = fld[gi].rhs;
    end
    chk("req_ready",  32'(req_ready),  32'(exp_rdy));
    chk("fpu_d_trig", 32'(fpu_d_trig), 32'(|exp_rdy));
    chk("fpu_d_mode", 32'(fpu_d_mode), 32'(e_mode));
    chk("fpu_d_lhs",  fpu_d_lhs,       e_lhs);
    chk("fpu_d_rhs",  fpu_d_rhs,       e_rhs);
    chk("rsp_valid",  32'(rsp_valid),  32'(exp_rsp));
    chk("rsp_res",    rsp_res,         exp_res);
    chk("busy",       32'(busy),       32'(rst && (sbq.size() > 0)));
    chk("err",        32'(err),        32'(exp_err));
    if (!rst) begin
      exp_err = 1'b0;
      sbq.delete();
    end else begin
      if (fpu_q_trig != slot) exp_err = 1'b1;
      if (slot) void'(sbq.pop_front());
      if (gi >= 0) sbq.push_back('{gi, cyc + LAT, fpu_calc(e_mode, e_lhs, e_rhs)});
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0; fpu_d_ready = 1'b1; inject = 1'b0; req_valid = '0;
    fld[0] = '{FPU_MUL, 32'h40000000, 32'h40000000};
    fld[1] = '{FPU_SUB, 32'h40800000, 32'h40000000};
    fld[2] = '{FPU_ADD, 32'h3F800000, 32'h40000000};
    fld[3] = '{FPU_DIV, 32'h3F800000, 32'h40000000};

    // Full rotation from reset, then drain
    add(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1);
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0001, 1);
      add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0010, 1);
      add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0100, 1);
      add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1000, 1);
    end
    add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 2);
    // Requesters 1 and 3 with ptr moved to 2; 3 drops out while 1 waits
    add(1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010, 1);
    add(1'b1, 1'b0, 1'b1, 4'b1010, 4'b1000, 1);
    add(1'b1, 1'b0, 1'b1, 4'b0010, 4'b0010, 1);
    add(1'b1, 1'b0, 1'b1, 4'b1010, 4'b1000, 1);
    add(1'b1, 1'b0, 1'b1, 4'b1010, 4'b0010, 1);
    // Lone requester granted back to back
    add(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001, 3);
    // FPU not ready for three cycles
    add(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 3);
    add(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001, 1);
    // Hold after two grants, pipe drains, then resume from saved pointer
    add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0010, 1);
    add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0100, 1);
    add(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 3);
    add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1000, 1);
    add(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0001, 1);
    add(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 2);

    @(posedge clk);
    #1;
    cycle('0);
    cycle('0);

    // Single op from requester 2: 1.0 + 2.0 returns 3.0 two cycles later
    rst = 1'b1;
    req_valid = 4'b0100;
    cycle(4'b0100);
    req_valid = '0;
    cycle('0); cycle('0); cycle('0);

    foreach (tbl[k]) begin
      rst         = tbl[k].r;
      hold        = tbl[k].h;
      fpu_d_ready = tbl[k].d;
      req_valid   = tbl[k].v;
      cycle(tbl[k].e);
    end

    // Reset with two ops in flight; their results return while in reset
    req_valid = 4'b0011;
    cycle(4'b0010);
    cycle(4'b0001);
    rst = 1'b0;
    cycle('0);
    req_valid = '0;
    cycle('0); cycle('0);
    rst = 1'b1;
    cycle('0); cycle('0);
    // Spurious result strobe with an empty pipe sets a sticky error
    inject = 1'b1;
    cycle('0);
    inject = 1'b0;
    cycle('0); cycle('0); cycle('0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
